// File: rtl/game_pkg.sv
// Shared game-link definitions.
// Used by the local game-mode controller, by the transmit side (game_state_tx)
// and by the peer-side decoder. Sharing one package keeps the link codes
// consistent with uart_state_selector on the peer board.
package game_pkg;

  typedef enum logic [1:0] {
    START       = 2'b00,
    GAME        = 2'b01,
    PLAYER1_WIN = 2'b10,
    PLAYER2_WIN = 2'b11
  } game_mode;

  typedef enum logic [1:0] {
    START_REQ = 2'b01,
    COLLISION = 2'b10,
    RESTART   = 2'b11
  } link_code_t;

  localparam logic [3:0] LINK_HDR = 4'hA;

  // Message byte on the wire: header nibble, two zero bits, code.
  function automatic logic [7:0] link_byte(input link_code_t code);
    return {LINK_HDR, 2'b00, code};
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// UART 8N1 byte serializer.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   start      : load request, accepted only while idle
//   data[7:0]  : byte captured together with start
//   tx         : serial line, idle high, LSB first
//   busy       : high from the first start-bit cycle through the last stop-bit cycle
//   done       : one-cycle pulse during the last stop-bit cycle
//
// state    | meaning
// SER_IDLE | line high, waiting for start
// SER_START| start bit (low) for CLKS_PER_BIT cycles
// SER_DATA | data bits 0..7, each CLKS_PER_BIT cycles
// SER_STOP | stop bit (high) for CLKS_PER_BIT cycles
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 564
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {SER_IDLE, SER_START, SER_DATA, SER_STOP} ser_state_t;

  ser_state_t    state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    data_q;
  logic          tx_q;
  logic          busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SER_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        SER_IDLE: begin
          if (start) begin
            state_q <= SER_START;
            data_q  <= data;
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        SER_START: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            state_q <= SER_DATA;
            tx_q    <= data_q[0];
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        SER_DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            if (bit_q == 3'd7) begin
              state_q <= SER_STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_q <= bit_q + 3'd1;
              tx_q  <= data_q[bit_q + 3'd1];
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        SER_STOP: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            state_q <= SER_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= SER_IDLE;
      endcase
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  // Decoded from registered state so the dispatcher can hand over on the
  // same edge the stop bit ends.
  assign done = (state_q == SER_STOP) && (cnt_q == CNT_LAST);

endmodule

// File: rtl/game_state_tx.sv
// Transmit side of the board-to-board game link.
// Detects local game events, keeps one pending flag per event code and
// sends each as a one-byte UART 8N1 message toward the peer board.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   mode              : local game mode
//   player1           : local player started the round
//   player1_collision : local snake collision level
//   tx                : UART line, idle high
//   busy              : a frame is on the line
//
// state  | meaning
// D_IDLE | no frame owned; picks the highest-priority pending flag
// D_SEND | frame loaded, waiting for the serializer done pulse
module game_state_tx
  import game_pkg::*;
#(
  parameter int CLK_HZ       = 65_000_000,
  parameter int BAUD         = 115_200,
  parameter int CLKS_PER_BIT = CLK_HZ / BAUD
) (
  input  logic     clk,
  input  logic     rst,
  input  game_mode mode,
  input  logic     player1,
  input  logic     player1_collision,
  output logic     tx,
  output logic     busy
);

  typedef enum logic {D_IDLE, D_SEND} disp_state_t;

  disp_state_t disp_q;
  game_mode    mode_q;
  logic        coll_q;
  logic        pend_start_q, pend_coll_q, pend_restart_q;
  logic        pend_start_d, pend_coll_d, pend_restart_d;

  logic        det_start, det_coll, det_restart;
  logic        clr_start, clr_coll, clr_restart;
  logic        load;
  link_code_t  sel_code;
  logic        ser_done;

  assign det_start   = (mode_q == START) && (mode == GAME) && player1;
  assign det_coll    = (mode == GAME) && player1_collision && !coll_q;
  assign det_restart = ((mode_q == PLAYER1_WIN) || (mode_q == PLAYER2_WIN)) && (mode == START);

  // Priority COLLISION > RESTART > START_REQ.
  always_comb begin
    load        = 1'b0;
    sel_code    = COLLISION;
    clr_start   = 1'b0;
    clr_coll    = 1'b0;
    clr_restart = 1'b0;
    if (disp_q == D_IDLE) begin
      if (pend_coll_q) begin
        load     = 1'b1;
        sel_code = COLLISION;
        clr_coll = 1'b1;
      end else if (pend_restart_q) begin
        load        = 1'b1;
        sel_code    = RESTART;
        clr_restart = 1'b1;
      end else if (pend_start_q) begin
        load      = 1'b1;
        sel_code  = START_REQ;
        clr_start = 1'b1;
      end
    end
  end

  // A detect in the same cycle as the clear re-arms the flag.
  assign pend_start_d   = (pend_start_q   && !clr_start)   || det_start;
  assign pend_coll_d    = (pend_coll_q    && !clr_coll)    || det_coll;
  assign pend_restart_d = (pend_restart_q && !clr_restart) || det_restart;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_q         <= D_IDLE;
      mode_q         <= START;
      coll_q         <= 1'b0;
      pend_start_q   <= 1'b0;
      pend_coll_q    <= 1'b0;
      pend_restart_q <= 1'b0;
    end else begin
      mode_q         <= mode;
      coll_q         <= player1_collision;
      pend_start_q   <= pend_start_d;
      pend_coll_q    <= pend_coll_d;
      pend_restart_q <= pend_restart_d;
      case (disp_q)
        D_IDLE:  if (load) disp_q <= D_SEND;
        D_SEND:  if (ser_done) disp_q <= D_IDLE;
        default: disp_q <= D_IDLE;
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_ser (
    .clk  (clk),
    .rst  (rst),
    .start(load),
    .data (link_byte(sel_code)),
    .tx   (tx),
    .busy (busy),
    .done (ser_done)
  );

endmodule

// File: doc/game_state_tx.md
# game_state_tx

Transmit side of the board-to-board game link. Watches the local game mode and player-1 events, encodes each local event as a one-byte message, and serializes it as UART 8N1 on `tx` toward the peer board. There, the UART receiver and decoder drive the 2-bit `uart_state_selector` into the peer's game-mode controller. The block sits beside the game-mode controller in the top level, fed by its `mode` and `player1` outputs.

## Interface
- `CLK_HZ`, default 65_000_000: system clock frequency in Hz.
- `BAUD`, default 115_200: line rate.
- `CLKS_PER_BIT`, default `CLK_HZ/BAUD` (564, truncating integer division): clocks per UART bit.

- `clk` — in, 1: system clock.
- `rst` — in, 1: asynchronous, active-high reset.
- `mode` — in, `game_mode`: current local game mode (START, GAME, PLAYER1_WIN, PLAYER2_WIN).
- `player1` — in, 1: local player started the round.
- `player1_collision` — in, 1: local snake collision (level; may last several cycles).
- `tx` — out, 1: UART line, idle high.
- `busy` — out, 1: a frame is on the line.

## Operation
- Message byte = {4'hA, 2'b00, code}. Codes: START_REQ=2'b01 (8'hA1), COLLISION=2'b10 (8'hA2), RESTART=2'b11 (8'hA3).
- Registered copies: `mode_q` (reset START), `coll_q` (reset 0).
- Event detect, each cycle:
  - START_REQ when `mode_q==START && mode==GAME && player1==1`. A transition caused by the peer (`player1==0`) sends nothing.
  - COLLISION when `mode==GAME && player1_collision && !coll_q`, i.e. a rising edge in GAME. Collisions in other modes are ignored.
  - RESTART when `mode_q` is PLAYER1_WIN or PLAYER2_WIN and `mode==START`.
- Each code has a pending flag, set on detect. A re-detect while pending coalesces: one frame only, no counting.
- Dispatcher FSM has two states.
  - IDLE: if any flag is pending, choose by priority COLLISION > RESTART > START_REQ. Clear that flag, load the byte into the serializer, go to SEND.
  - SEND: wait for the serializer done pulse, then return to IDLE.
- Serializer FSM states are IDLE, START, DATA, STOP.
  - START drives `tx=0` for CLKS_PER_BIT cycles.
  - DATA sends bits 0..7, LSB first, each for CLKS_PER_BIT cycles.
  - STOP drives `tx=1` for CLKS_PER_BIT cycles.
  - The bit counter is 3 bits. The baud counter counts 0..CLKS_PER_BIT-1 and has width `$clog2(CLKS_PER_BIT)`.
- `busy`=1 from the first start-bit cycle through the last stop-bit cycle.
- Flags can be set while a frame is in SEND. Setting a flag never disturbs the frame in progress.

## Timing
- Reset values: `tx`=1, `busy`=0, all flags 0, both FSMs IDLE, counters 0. Reset is asynchronous: `tx` goes high and `busy` goes low immediately, even mid-frame. The partial frame is dropped, with no resume.
- Latency:
  - Event detected at edge k sets its flag at edge k.
  - If idle, the dispatcher loads at edge k+1, and `tx` falls and `busy` rises after edge k+1.
- A frame lasts exactly 10·CLKS_PER_BIT cycles (5640 at defaults).
- Back-to-back: the next pending frame's start bit begins 1 cycle after the previous stop bit ends, so the line sees one extra idle-high cycle.
- Simultaneous detects in the same cycle set both flags. The frames go out in priority order.
- An event detected in the cycle the dispatcher clears the same flag re-sets it, producing a second frame. The set wins over the clear.

## Structure
- `game_pkg` holds:
  - existing `game_mode`;
  - new `link_code_t` (2-bit enum: START_REQ, COLLISION, RESTART) and `LINK_HDR = 4'hA`.
- The peer-side decoder uses the same package, so codes match `uart_state_selector`.
- Sub-module `uart_tx_byte`: ports `clk`, `rst`, `start`, `data[7:0]` → `tx`, `busy`, `done`. `done` is a 1-cycle pulse in the last STOP cycle. It is parameterized by CLKS_PER_BIT.
- The top module holds event detection, pending flags and the dispatcher.

## Test plan
- Reset is asserted mid-frame (around bit 4 of 8'hA2) → `tx`=1 and `busy`=0 in the same cycle. After release, no frame until a new event.
- `mode` goes START→GAME with `player1=1` → `tx` falls 1 cycle later. Sample at bit centres (CLKS_PER_BIT/2 + n·564) → start bit 0, then bits 1,0,0,0,0,1,0,1 (8'hA1), then stop 1. `busy` is high for 5640 cycles.
- START→GAME with `player1=0` → `tx` stays high for 20000 cycles.
- In GAME, `player1_collision` is held high for 50 cycles → exactly one 8'hA2 frame. The same pulse in PLAYER2_WIN → no frame.
- COLLISION and RESTART are raised during an ongoing 8'hA1 frame → frames 8'hA1, 8'hA2, 8'hA3 in that order, each gap exactly 1 idle cycle.
- RESTART is detected in the cycle its flag is being cleared → two 8'hA3 frames.
